// File: rtl/cnt_pkg.sv
// Shared types for the down-counter load controller.
// Holds the FSM state encoding and the default data width.
package cnt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } ld_state_t;

  localparam int CNT_DW = 4;

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser, debounce counter and rising-edge pulse.
// Ports: clk, rstn, btn_i (raw async button), start_o (1-cycle pulse on debounced rise).
module btn_debounce #(
  parameter int DB_CYCLES = 1000000,
  parameter int SYNC_STG  = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_i,
  output logic start_o
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STG-1:0] sync_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                db_q, db_d;
  logic                db_dly_q;
  logic                sync_w;

  assign sync_w = sync_q[SYNC_STG-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STG-2:0], btn_i};
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      db_dly_q <= db_q;
    end
  end

  // Any return to the accepted level restarts the stability window.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync_w == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      db_d  = sync_w;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign start_o = db_q & ~db_dly_q;

endmodule

// File: rtl/cnt_load_ctrl.sv
// Load controller for a loadable down-counter: debounced start, load pulse, expiry detect.
// Ports: clk, rstn, btn_raw, sw_din, auto_reload, q_in -> pe, din, busy, done.
module cnt_load_ctrl
  import cnt_pkg::*;
#(
  parameter int DW        = CNT_DW,
  parameter int DB_CYCLES = 1000000,
  parameter int SYNC_STG  = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          btn_raw,
  input  logic [DW-1:0] sw_din,
  input  logic          auto_reload,
  input  logic [DW-1:0] q_in,
  output logic          pe,
  output logic [DW-1:0] din,
  output logic          busy,
  output logic          done
);

  ld_state_t     state_q, state_d;
  logic [DW-1:0] din_q, din_d;
  logic          start;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .SYNC_STG  (SYNC_STG)
  ) u_db (
    .clk     (clk),
    .rstn    (rstn),
    .btn_i   (btn_raw),
    .start_o (start)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
    end
  end

  // A start always wins: it resamples the switches from any
  // state that can accept it, including mid-count.
  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          din_d   = sw_din;
          state_d = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (start) begin
          din_d   = sw_din;
          state_d = LOAD;
        end else if (q_in == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          din_d   = sw_din;
          state_d = LOAD;
        end else if (auto_reload) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pe   = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      LOAD: begin
        pe   = 1'b1;
        busy = 1'b1;
      end
      RUN:  busy = 1'b1;
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign din = din_q;

endmodule

// File: tb/tb_cnt_load_ctrl.sv
// Directed bench for cnt_load_ctrl paired with a behavioural down-counter.
// Each task drives one scenario and checks its own expected values.
module tb_cnt_load_ctrl;

  localparam int DW  = 4;
  localparam int DBC = 4;
  localparam int SS  = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          btn_raw = 1'b0;
  logic [DW-1:0] sw_din = '0;
  logic          auto_reload = 1'b0;
  logic [DW-1:0] q = '0;
  logic          pe;
  logic [DW-1:0] din;
  logic          busy;
  logic          done;

  int total = 0;
  int bad = 0;
  int pe_cnt = 0;
  int done_cnt = 0;
  bit pe_prev = 0;

  always #5 clk = ~clk;

  cnt_load_ctrl #(
    .DW        (DW),
    .DB_CYCLES (DBC),
    .SYNC_STG  (SS)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .btn_raw     (btn_raw),
    .sw_din      (sw_din),
    .auto_reload (auto_reload),
    .q_in        (q),
    .pe          (pe),
    .din         (din),
    .busy        (busy),
    .done        (done)
  );

  // Saturating loadable down-counter.
  always @(posedge clk) begin
    if (pe) q <= din;
    else if (q != 0) q <= q - 1'b1;
  end

  always @(negedge clk) begin
    if (!rstn) begin
      pe_prev = 0;
    end else begin
      if (pe) begin
        pe_cnt++;
        total++;
        if (pe_prev) begin
          bad++;
          $display("FAIL pe_width got=2+ cycles want=1");
        end
      end
      if (done) done_cnt++;
      pe_prev = pe;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_pe(output int n, output bit ok);
    n  = 0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      n++;
      ok = pe;
    end
  endtask

  task automatic wait_done(output int n, output bit ok);
    n  = 0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      n++;
      ok = done;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    tick(3);
    total++;
    if ({pe, busy, done, din} !== '0) begin
      bad++;
      $display("FAIL rst_out got=%b want=0", {pe, busy, done, din});
    end
    rstn = 1'b1;
    tick(3);
    total++;
    if (busy !== 1'b0 || pe !== 1'b0) begin
      bad++;
      $display("FAIL rst_idle got=%b%b want=00", busy, pe);
    end
  endtask

  task automatic test_clean_press;
    int n;
    bit ok;
    int p0;
    p0 = pe_cnt;
    sw_din  = 4'd5;
    btn_raw = 1'b1;
    wait_pe(n, ok);
    // n counts edges up to the one that raised pe; the counter
    // captures it on the following edge.
    total++;
    if (!ok || n + 1 != SS + DBC + 2) begin
      bad++;
      $display("FAIL press_lat got=%0d want=%0d", n + 1, SS + DBC + 2);
    end
    total++;
    if (din !== 4'd5) begin
      bad++;
      $display("FAIL press_din got=%0d want=5", din);
    end
    tick();
    for (int k = 5; k >= 0; k--) begin
      total++;
      if (q !== DW'(k) || done !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL count q got=%0d want=%0d done=%b busy=%b", q, k, done, busy);
      end
      tick();
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL done_pulse got=%b want=1", done);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL back_idle got=%b%b want=00", done, busy);
    end
    btn_raw = 1'b0;
    tick(20);
    total++;
    if (pe_cnt - p0 != 1) begin
      bad++;
      $display("FAIL press_pe_cnt got=%0d want=1", pe_cnt - p0);
    end
  endtask

  task automatic test_bounce;
    int p0;
    int d0;
    p0 = pe_cnt;
    d0 = done_cnt;
    sw_din = 4'd1;
    for (int i = 0; i < 10; i++) begin
      btn_raw = ~btn_raw;
      tick(2);
    end
    btn_raw = 1'b1;
    tick(50);
    total++;
    if (pe_cnt - p0 != 1) begin
      bad++;
      $display("FAIL bounce_pe got=%0d want=1", pe_cnt - p0);
    end
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL bounce_done got=%0d want=1", done_cnt - d0);
    end
    btn_raw = 1'b0;
    tick(20);
    total++;
    if (pe_cnt - p0 != 1) begin
      bad++;
      $display("FAIL release_pe got=%0d want=1", pe_cnt - p0);
    end
  endtask

  task automatic test_auto_reload;
    int n;
    bit ok;
    auto_reload = 1'b1;
    sw_din  = 4'd3;
    btn_raw = 1'b1;
    wait_pe(n, ok);
    total++;
    if (!ok || din !== 4'd3) begin
      bad++;
      $display("FAIL ar_pe ok=%b din got=%0d want=3", ok, din);
    end
    btn_raw = 1'b0;
    sw_din  = 4'd7;
    tick(2);
    total++;
    if (din !== 4'd3) begin
      bad++;
      $display("FAIL ar_hold got=%0d want=3", din);
    end
    wait_done(n, ok);
    total++;
    if (!ok || n != 3) begin
      bad++;
      $display("FAIL ar_done_lat got=%0d want=3", n);
    end
    tick();
    total++;
    if (pe !== 1'b1 || din !== 4'd3) begin
      bad++;
      $display("FAIL ar_reload pe=%b din got=%0d want=3", pe, din);
    end
    auto_reload = 1'b0;
    wait_done(n, ok);
    total++;
    if (!ok || n != 5) begin
      bad++;
      $display("FAIL ar_done2_lat got=%0d want=5", n);
    end
    tick();
    total++;
    if (busy !== 1'b0 || pe !== 1'b0) begin
      bad++;
      $display("FAIL ar_idle got=%b%b want=00", busy, pe);
    end
    tick(10);
  endtask

  task automatic test_restart;
    int n;
    bit ok;
    int d0;
    sw_din  = 4'd15;
    btn_raw = 1'b1;
    wait_pe(n, ok);
    btn_raw = 1'b0;
    for (int i = 0; i < 40 && q != 4'd10; i++) tick();
    total++;
    if (q !== 4'd10) begin
      bad++;
      $display("FAIL rs_wait q got=%0d want=10", q);
    end
    d0 = done_cnt;
    sw_din  = 4'd2;
    btn_raw = 1'b1;
    wait_pe(n, ok);
    total++;
    if (!ok || din !== 4'd2 || done_cnt != d0) begin
      bad++;
      $display("FAIL rs_pe ok=%b din got=%0d want=2 dones=%0d", ok, din, done_cnt - d0);
    end
    btn_raw = 1'b0;
    wait_done(n, ok);
    total++;
    if (!ok || n != 4 || q !== 4'd0) begin
      bad++;
      $display("FAIL rs_done lat got=%0d want=4 q=%0d", n, q);
    end
    tick(10);
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL rs_done_cnt got=%0d want=1", done_cnt - d0);
    end
  endtask

  task automatic test_zero_preset;
    int n;
    bit ok;
    sw_din  = 4'd0;
    btn_raw = 1'b1;
    wait_pe(n, ok);
    btn_raw = 1'b0;
    total++;
    if (!ok || din !== 4'd0) begin
      bad++;
      $display("FAIL zp_pe ok=%b din got=%0d want=0", ok, din);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b1 || q !== 4'd0) begin
      bad++;
      $display("FAIL zp_run done=%b busy=%b q=%0d want 0 1 0", done, busy, q);
    end
    tick();
    total++;
    if (done !== 1'b1 || q !== 4'd0) begin
      bad++;
      $display("FAIL zp_done got=%b q=%0d want=1", done, q);
    end
    tick();
    total++;
    if (busy !== 1'b0 || q !== 4'd0) begin
      bad++;
      $display("FAIL zp_idle busy=%b q=%0d want 0 0", busy, q);
    end
    tick(10);
  endtask

  task automatic test_reset_mid_run;
    int n;
    bit ok;
    int p0;
    sw_din  = 4'd9;
    btn_raw = 1'b1;
    wait_pe(n, ok);
    btn_raw = 1'b0;
    for (int i = 0; i < 40 && q != 4'd5; i++) tick();
    total++;
    if (q !== 4'd5 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mr_wait q got=%0d want=5 busy=%b", q, busy);
    end
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if ({pe, busy, done, din} !== '0) begin
      bad++;
      $display("FAIL mr_async got=%b want=0", {pe, busy, done, din});
    end
    tick(3);
    rstn = 1'b1;
    p0 = pe_cnt;
    tick(12);
    total++;
    if (busy !== 1'b0 || pe_cnt != p0 || din !== 4'd0) begin
      bad++;
      $display("FAIL mr_idle busy=%b pe=%0d din=%0d want 0 0 0", busy, pe_cnt - p0, din);
    end
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_auto_reload;
    test_restart;
    test_zero_preset;
    test_reset_mid_run;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
